// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types, constants and baud divisor helper
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Rounded clk cycles per oversample tick.
    function automatic int div_calc(input longint clk_freq, input longint baud);
        longint os_rate;
        os_rate = baud * longint'(OVERSAMPLE);
        return int'((clk_freq + baud * longint'(OVERSAMPLE / 2)) / os_rate);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready handshake and status flags
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, rx_busy, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, counts 0..DIV-1 with synchronous clear
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampling, mid-bit sampling, valid/ready output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master bus
);
    localparam int DIV = div_calc(longint'(CLK_FREQ), longint'(BAUD));
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           r_rst_pipe;
    logic                 w_rst;
    logic                 r_sync1, r_sync2, w_rxd_s;
    rx_state_t            r_state, w_state_next;
    logic [3:0]           r_sample;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_deliver, r_valid, r_frame_err, r_overrun;
    logic                 w_tick, w_clr, w_enter_data, w_shift_en, w_stop_ok, w_stop_bad;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_pipe <= 2'b11;
        else     r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
    assign w_rst = r_rst_pipe[1];

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rxd_s = r_sync2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (w_rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_enter_data = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxd_s) begin
                    w_clr        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick && (r_sample == 4'd7)) begin
                    if (!w_rxd_s) begin
                        w_enter_data = 1'b1;
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick && (r_sample == 4'd15)) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_BIT) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && (r_sample == 4'd15)) begin
                    if (w_rxd_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxd_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_sample  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_clr || w_enter_data) r_sample <= '0;
            else if (w_tick)           r_sample <= r_sample + 4'd1;

            if (w_enter_data)    r_bit_idx <= '0;
            else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;

            if (w_shift_en) r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
        end
    end

    // A new byte may replace the held one only if the consumer takes the old one this cycle.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
        end else begin
            r_deliver   <= w_stop_ok;
            r_frame_err <= w_stop_bad;
            r_overrun   <= r_deliver && r_valid && !bus.rx_ready;
            if (r_deliver && (!r_valid || bus.rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.rx_busy   = (r_state != ST_IDLE);
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx
module tb_uart_rx;
    localparam int CLK_P = 10000;
    localparam int BIT_P = 864 * CLK_P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    int   half_p = CLK_P / 2;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] acc_q[$];
    int fe_cnt = 0, ov_cnt = 0, busy_cyc = 0, valid_cyc = 0, hold_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    int b_acc, b_fe, b_ov, b_busy, b_valid;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLK_FREQ(100000000), .BAUD(115200), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    always #(half_p) clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) acc_q.push_back(bus.rx_data);
        if (bus.frame_err) fe_cnt <= fe_cnt + 1;
        if (bus.overrun)   ov_cnt <= ov_cnt + 1;
        if (bus.rx_busy)   busy_cyc <= busy_cyc + 1;
        if (bus.rx_valid)  valid_cyc <= valid_cyc + 1;
        if (prev_stall && bus.rx_valid && (bus.rx_data != prev_data)) hold_bad <= hold_bad + 1;
        prev_stall <= bus.rx_valid && !bus.rx_ready;
        prev_data  <= bus.rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int idx);
        if (idx < acc_q.size()) return {24'h0, acc_q[idx]};
        return 32'hBAD;
    endfunction

    task automatic snap();
        b_acc   = acc_q.size();
        b_fe    = fe_cnt;
        b_ov    = ov_cnt;
        b_busy  = busy_cyc;
        b_valid = valid_cyc;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        #(BIT_P);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(BIT_P);
        end
        rxd = stop;
        #(BIT_P);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #(CLK_P / 10);
        bus.rx_ready = v;
    endtask

    initial begin
        int d;
        bus.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #(CLK_P / 10);
        check("rst_valid", 32'(bus.rx_valid), 0);
        check("rst_data", 32'(bus.rx_data), 0);
        check("rst_busy", 32'(bus.rx_busy), 0);
        check("rst_ferr", 32'(bus.frame_err), 0);
        check("rst_ovr", 32'(bus.overrun), 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 0x55 with consumer always ready
        snap();
        send_byte(8'h55, 1'b1);
        #(BIT_P / 2);
        check("t1_count", 32'(acc_q.size() - b_acc), 1);
        check("t1_data", acc_at(b_acc), 32'h55);
        check("t1_ferr", 32'(fe_cnt - b_fe), 0);
        check("t1_ovr", 32'(ov_cnt - b_ov), 0);
        check("t1_valid_len", 32'(valid_cyc - b_valid), 1);
        d = busy_cyc - b_busy;
        check("t1_busy_len", 32'(d >= 8200 && d <= 8216), 1);
        check("t1_busy_end", 32'(bus.rx_busy), 0);

        // 200-clk low glitch on idle line
        snap();
        rxd = 1'b0;
        #(200 * CLK_P);
        rxd = 1'b1;
        #(BIT_P);
        check("t2_count", 32'(acc_q.size() - b_acc), 0);
        check("t2_ferr", 32'(fe_cnt - b_fe), 0);
        check("t2_ovr", 32'(ov_cnt - b_ov), 0);
        d = busy_cyc - b_busy;
        check("t2_busy_len", 32'(d >= 425 && d <= 440), 1);
        check("t2_busy_end", 32'(bus.rx_busy), 0);

        // 0xA3 with bad stop bit, line held low, then 0x3C
        snap();
        send_byte(8'hA3, 1'b0);
        #(2000 * CLK_P);
        check("t3_break_busy", 32'(bus.rx_busy), 1);
        check("t3_ferr_once", 32'(fe_cnt - b_fe), 1);
        rxd = 1'b1;
        #(BIT_P / 2);
        send_byte(8'h3C, 1'b1);
        #(BIT_P / 2);
        check("t3_ferr_total", 32'(fe_cnt - b_fe), 1);
        check("t3_count", 32'(acc_q.size() - b_acc), 1);
        check("t3_data", acc_at(b_acc), 32'h3C);
        check("t3_ovr", 32'(ov_cnt - b_ov), 0);

        // consumer stalled: 0x11 held, 0x22 dropped
        set_ready(1'b0);
        snap();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        #(BIT_P / 2);
        check("t4_valid_held", 32'(bus.rx_valid), 1);
        check("t4_data_held", 32'(bus.rx_data), 32'h11);
        check("t4_ovr_once", 32'(ov_cnt - b_ov), 1);
        check("t4_no_xfer", 32'(acc_q.size() - b_acc), 0);
        check("t4_data_stable", 32'(hold_bad), 0);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #(CLK_P / 10);
        check("t4_xfer_count", 32'(acc_q.size() - b_acc), 1);
        check("t4_xfer_data", acc_at(b_acc), 32'h11);
        check("t4_valid_drop", 32'(bus.rx_valid), 0);

        // reset mid-DATA of 0xF0, then 0x0F
        rxd = 1'b0;
        #(BIT_P);
        #(BIT_P * 2 + BIT_P / 2);
        check("t5_busy_pre", 32'(bus.rx_busy), 1);
        rst = 1'b1;
        #(CLK_P / 10);
        check("t5_rst_busy", 32'(bus.rx_busy), 0);
        check("t5_rst_data", 32'(bus.rx_data), 0);
        check("t5_rst_valid", 32'(bus.rx_valid), 0);
        check("t5_rst_ferr", 32'(bus.frame_err), 0);
        check("t5_rst_ovr", 32'(bus.overrun), 0);
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #(CLK_P / 10);
        rst = 1'b0;
        #(BIT_P);
        snap();
        send_byte(8'h0F, 1'b1);
        #(BIT_P / 2);
        check("t5_count", 32'(acc_q.size() - b_acc), 1);
        check("t5_data", acc_at(b_acc), 32'h0F);
        check("t5_ferr", 32'(fe_cnt - b_fe), 0);

        // clock 2.5% fast against nominal line rate
        half_p = 4878;
        #(BIT_P);
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        #(BIT_P / 2);
        check("t6_count", 32'(acc_q.size() - b_acc), 2);
        check("t6_data0", acc_at(b_acc), 32'h00);
        check("t6_data1", acc_at(b_acc + 1), 32'hFF);
        check("t6_ferr", 32'(fe_cnt - b_fe), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
